// File: rtl/slot_pkg.sv
// Shared types and default timing constants for the slot-machine button front end.
package slot_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_t;

  localparam int unsigned DB_CYCLES_50M   = 500000;
  localparam int unsigned LONG_CYCLES_50M = 50000000;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/button_conditioner.sv
// Start/stop button conditioner: synchronise, debounce, then emit press,
// release and long-press events from a three-state FSM.
module button_conditioner
  import slot_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_50M,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic held
);

  localparam int unsigned DB_W   = cnt_width(DB_CYCLES);
  localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

  logic btn_sync;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  logic [DB_W-1:0] db_cnt;
  logic            stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      stable <= 1'b0;
    end else if (btn_sync == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_MAX) begin
      stable <= ~stable;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  btn_state_t      state, state_d;
  logic [LONG_W-1:0] long_cnt, long_cnt_d;
  logic            press_d, release_d, long_d;

  always_comb begin
    state_d    = state;
    long_cnt_d = long_cnt;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state)
      RELEASED: begin
        if (stable) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          long_cnt_d = '0;
        end
      end
      PRESSED: begin
        // Release is tested first so it wins a tie with the long threshold.
        if (!stable) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else if (long_cnt == LONG_MAX) begin
          state_d = HELD;
          long_d  = 1'b1;
        end else begin
          long_cnt_d = long_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!stable) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      long_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_d;
      long_cnt      <= long_cnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
    end
  end

  assign btn_level = stable;
  assign held      = (state == HELD);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an event scoreboard (DB=4, LONG=20).
module tb_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned LG = 20;
  localparam int unsigned LAT = DB + 3;

  localparam logic [2:0] EV_PRESS   = 3'b100;
  localparam logic [2:0] EV_RELEASE = 3'b010;
  localparam logic [2:0] EV_LONG    = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, held;

  button_conditioner #(.DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  code;
    int unsigned at;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input logic [2:0] code, input int unsigned at);
    ev_t e;
    e.code = code;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Drive a new raw level; the matching event is due LAT edges later.
  task automatic set_raw(input logic v);
    btn_raw = v;
    expect_ev(v ? EV_PRESS : EV_RELEASE, cyc + LAT);
  endtask

  // Outputs are sampled mid-cycle, half a period after the edge that produced them.
  logic [2:0] code;
  ev_t        got;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      check("missed_event_due", cyc, sb[0].at);
      void'(sb.pop_front());
    end
    code = {press_pulse, release_pulse, long_pulse};
    if ((|code) === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'd0, code}, 32'd0);
      end else begin
        got = sb.pop_front();
        check("event_kind", {29'd0, code}, {29'd0, got.code});
        check("event_cycle", cyc, got.at);
      end
    end
  end

  int unsigned t;

  initial begin
    // 1: reset held with button down; nothing may come out until after release.
    rst = 1'b1;
    btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_outputs", {27'd0, btn_level, press_pulse, release_pulse, long_pulse, held}, 32'd0);
    end
    rst = 1'b0;
    expect_ev(EV_PRESS, cyc + LAT);
    tick(LAT);
    check("reset_press_level", {31'd0, btn_level}, 32'd1);
    set_raw(1'b0);
    tick(LAT + 6);
    check("rel1_level", {31'd0, btn_level}, 32'd0);

    // 2: bounce, then settle high.
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    set_raw(1'b1);
    tick(LAT);
    set_raw(1'b0);
    tick(LAT + 6);

    // 3: short press.
    t = cyc;
    set_raw(1'b1);
    tick(LAT + 1);
    check("short_held_during", {31'd0, held}, 32'd0);
    tick(10 - (LAT + 1));
    set_raw(1'b0);
    tick(LAT + 6);
    check("short_held_after", {31'd0, held}, 32'd0);

    // 4: long press of 40 cycles.
    t = cyc;
    set_raw(1'b1);
    expect_ev(EV_LONG, t + LAT + LG);
    tick(LAT + LG - 1);
    check("long_held_before", {31'd0, held}, 32'd0);
    tick(2);
    check("long_held_on", {31'd0, held}, 32'd1);
    tick(40 - (LAT + LG + 1));
    set_raw(1'b0);
    tick(LAT - 1);
    check("long_held_until_rel", {31'd0, held}, 32'd1);
    tick(2);
    check("long_held_off", {31'd0, held}, 32'd0);
    tick(6);

    // 5: stable falls on the long-threshold cycle; release must win.
    set_raw(1'b1);
    tick(LG);
    set_raw(1'b0);
    tick(LAT + 1);
    check("tie_held", {31'd0, held}, 32'd0);
    check("tie_level", {31'd0, btn_level}, 32'd0);
    tick(6);

    // 6: reset while HELD, button stays down.
    t = cyc;
    set_raw(1'b1);
    expect_ev(EV_LONG, t + LAT + LG);
    tick(LAT + LG + 3);
    check("pre_reset_held", {31'd0, held}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_reset_held", {31'd0, held}, 32'd0);
    check("mid_reset_level", {31'd0, btn_level}, 32'd0);
    expect_ev(EV_PRESS, cyc + LAT);
    tick(LAT);
    check("repress_level", {31'd0, btn_level}, 32'd1);
    set_raw(1'b0);
    tick(LAT + 6);

    check("queue_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
